skew_feeder: RTL and testbench
==============================

# skew_feeder

Double-buffered, handshaked input skew buffer for the systolic array's A-operand edge. It accepts a tile of A one K-column per beat over a valid/ready interface, then streams it into the array rows with row r delayed by r cycles. While one bank streams, the other bank loads the next tile. It supports non-square tiles (ROWS × DEPTH), stalling through stream_en, and a synchronous clear.

## Interface
- ROWS, 8: array rows fed (output lanes)
- DEPTH, 8: K elements per row per tile (load beats per tile)
- DATA_WIDTH, 8: signed element width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous: empty both banks, abort stream, reset counters
- load_valid  in  1  load beat offered
- load_ready  out  1  current write bank is empty
- load_data  in  ROWS×DATA_WIDTH signed  one K-column; lane r = A[r][k]
- stream_en  in  1  array advance; 0 = stall (counter frozen, outputs held)
- data_out  out  ROWS×DATA_WIDTH signed  skewed operand per row, registered
- out_valid  out  ROWS  per-row element-valid, registered
- tile_done  out  1  one-cycle pulse with the last output beat of a tile
- busy  out  1  either bank full or stream in progress

## Operation
- Storage: 2 banks × DEPTH × ROWS × DATA_WIDTH. Per-bank full flag. Write-bank pointer wb and read-bank pointer rb, each 1 bit.
- Load: a beat is accepted on valid && ready. It writes load_data to bank wb at column wk, then increments wk. On the beat with wk == DEPTH-1: set full[wb], set wk to 0, toggle wb. load_ready = !full[wb], taken from registers only.
- Stream: stream counter t runs from 0 to DEPTH+ROWS-2.
- On each edge with stream_en=1 and full[rb]=1, for each row r:
  - data_out[r] <= mem[rb][t-r][r] and out_valid[r] <= 1 when 0 ≤ t-r < DEPTH.
  - Otherwise data_out[r] <= 0 and out_valid[r] <= 0.
  - Then t increments.
- Tile end: on the edge where t == DEPTH+ROWS-2 advances:
  - tile_done <= 1
  - clear full[rb], toggle rb, set t to 0.
  - If the other bank is full, the next tile's t=0 beat follows on the next enabled edge with no gap.
- stream_en=1 with full[rb]=0: data_out <= 0, out_valid <= 0, tile_done <= 0.
- stream_en=0: t frozen, data_out and out_valid held, tile_done <= 0. Loading continues during a stall.
- Simultaneous events:
  - A load that completes bank X and a stream that frees bank Y in the same cycle both take effect.
  - A bank freed at edge E shows load_ready=1 from E onward; its first write lands at E+1 at the earliest.
- clear: full flags, wk, t, wb, rb and all outputs go to 0. Stored data is don't-care. clear overrides a load beat and a stream advance in the same cycle.
- Counter widths: wk uses max(1,$clog2(DEPTH)) bits; t uses max(1,$clog2(DEPTH+ROWS-1)) bits. No wrap beyond the terminal values.

## Timing
- Reset values: load_ready=1, data_out=0, out_valid=0, tile_done=0, busy=0; wb=rb=0, wk=t=0, full=00.
- Load-to-stream latency: last load beat accepted at edge E0 sets full at E0. The earliest first output (row 0, k=0) is registered at E1, provided stream_en=1.
- One tile occupies DEPTH+ROWS-1 enabled stream cycles. Row r is valid on enabled cycles t = r … r+DEPTH-1.
- Sustained throughput is one tile per DEPTH+ROWS-1 cycles, as long as loads keep pace (DEPTH beats ≤ stream length).
- rst asserted mid-stream or mid-load: outputs go to reset values immediately. Partial tiles are discarded.

## Test plan
- Basic skew, ROWS=4, DEPTH=3: load beats with lane r = 16r+k for k=0..2, then stream_en=1.
  - Outputs at t=0..5: row0 = 0,1,2 at t=0..2; row3 = 48,49,50 at t=3..5.
  - At t=2: data_out = {2,17,32,0}, out_valid = 1110.
  - tile_done pulses at t=5 only.
- Ping-pong: load tile B (values +100) during tile A's stream. Tile B's t=0 output (row0=100) directly follows tile A's t=5 with no gap. load_ready=0 while both banks are full.
- Stall: drop stream_en for 3 cycles at t=2. data_out and out_valid hold {2,17,32,0}/1110. Resume continues at t=3 = {·,18,33,48}. Total enabled cycles remain 6.
- Backpressure: with both banks full, hold load_valid=1. No beat is accepted until the edge that frees a bank. The following beat writes k=0 of the freed bank.
- clear mid-stream at t=3 with the other bank half loaded:
  - Next cycle: out_valid = 0000, busy = 0, load_ready = 1.
  - A fresh 3-beat load then streams correctly from k=0.
- Async reset asserted between edges during streaming: outputs drop to 0 immediately. After release, behaviour matches the post-reset state.

Source files
------------

// File: rtl/skew_feeder_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// skew_feeder_if : load handshake and skewed stream bus of skew_feeder
// rev 1.0
// ----------------------------------------------------------------------
interface skew_feeder_if #(
   parameter int ROWS       = 8,
   parameter int DATA_WIDTH = 8
);
   logic                                 clear;
   logic                                 load_valid;
   logic                                 load_ready;
   logic signed [ROWS-1:0][DATA_WIDTH-1:0] load_data;
   logic                                 stream_en;
   logic signed [ROWS-1:0][DATA_WIDTH-1:0] data_out;
   logic [ROWS-1:0]                      out_valid;
   logic                                 tile_done;
   logic                                 busy;

   modport master (
      output clear, load_valid, load_data, stream_en,
      input  load_ready, data_out, out_valid, tile_done, busy
   );

   modport slave (
      input  clear, load_valid, load_data, stream_en,
      output load_ready, data_out, out_valid, tile_done, busy
   );
endinterface
`default_nettype wire

// File: rtl/skew_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------
// skew_feeder : double-buffered A-operand skew buffer, row r delayed r cycles
// rev 1.0
// ----------------------------------------------------------------------
module skew_feeder #(
   parameter int ROWS       = 8,
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,
   skew_feeder_if.slave  bus
);
   localparam int KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW = (DEPTH + ROWS - 1 > 1) ? $clog2(DEPTH + ROWS - 1) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(DEPTH - 1);
   localparam logic [TW-1:0] T_LAST = TW'(DEPTH + ROWS - 2);

   typedef logic [ROWS-1:0][DATA_WIDTH-1:0] col_t;

   col_t            mem [2][DEPTH];
   logic [1:0]      full;
   logic            wb;
   logic            rb;
   logic [KW-1:0]   wk;
   logic [TW-1:0]   t;
   col_t            data_q;
   col_t            rd;
   logic [ROWS-1:0] valid_q;
   logic [ROWS-1:0] win;
   logic            done_q;
   logic            accept;
   logic            advance;

   assign bus.load_ready = !full[wb];
   assign bus.data_out   = data_q;
   assign bus.out_valid  = valid_q;
   assign bus.tile_done  = done_q;
   assign bus.busy       = |full;

   assign accept  = bus.load_valid && !full[wb] && !bus.clear;
   assign advance = bus.stream_en && full[rb] && !bus.clear;

   // One extra bit so r+DEPTH never overflows the window comparison.
   generate
      for (genvar r = 0; r < ROWS; r++) begin : g_row
         logic [TW:0]   t_ext;
         logic [TW:0]   rel;
         logic [KW-1:0] col;
         assign t_ext  = {1'b0, t};
         assign rel    = t_ext - (TW+1)'(r);
         assign win[r] = (t_ext >= (TW+1)'(r)) && (t_ext < (TW+1)'(r + DEPTH));
         assign col    = KW'(rel);
         assign rd[r]  = mem[rb][col][r];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wb][wk] <= bus.load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full    <= 2'b00;
         wb      <= 1'b0;
         rb      <= 1'b0;
         wk      <= '0;
         t       <= '0;
         data_q  <= '0;
         valid_q <= '0;
         done_q  <= 1'b0;
      end else if (bus.clear) begin
         full    <= 2'b00;
         wb      <= 1'b0;
         rb      <= 1'b0;
         wk      <= '0;
         t       <= '0;
         data_q  <= '0;
         valid_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            if (wk == K_LAST) begin
               wk       <= '0;
               wb       <= ~wb;
               full[wb] <= 1'b1;
            end else begin
               wk <= wk + 1'b1;
            end
         end
         // A completing load always targets the bank opposite the one freed here.
         if (advance) begin
            for (int r = 0; r < ROWS; r++) begin
               data_q[r] <= win[r] ? rd[r] : '0;
            end
            valid_q <= win;
            if (t == T_LAST) begin
               t        <= '0;
               rb       <= ~rb;
               full[rb] <= 1'b0;
               done_q   <= 1'b1;
            end else begin
               t <= t + 1'b1;
            end
         end else if (bus.stream_en) begin
            data_q  <= '0;
            valid_q <= '0;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_skew_feeder.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_skew_feeder : directed self-checking bench, ROWS=4 DEPTH=3
// rev 1.0
// ----------------------------------------------------------------------
module tb_skew_feeder;
   logic clk = 1'b0;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   skew_feeder_if #(.ROWS(4), .DATA_WIDTH(8)) sf ();

   skew_feeder #(.ROWS(4), .DEPTH(3), .DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (sf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Lane r of column k of a tile with offset base holds base + 16r + k.
   function automatic logic [31:0] col(input int base, input int k);
      logic [31:0] v;
      v = '0;
      for (int r = 0; r < 4; r++) v[r*8 +: 8] = 8'(base + 16*r + k);
      return v;
   endfunction

   function automatic logic [31:0] exp_out(input int base, input int t);
      logic [31:0] v;
      v = '0;
      for (int r = 0; r < 4; r++)
         if (t >= r && t < r + 3) v[r*8 +: 8] = 8'(base + 16*r + t - r);
      return v;
   endfunction

   function automatic logic [3:0] exp_valid(input int t);
      logic [3:0] v;
      v = '0;
      for (int r = 0; r < 4; r++) v[r] = (t >= r && t < r + 3);
      return v;
   endfunction

   task automatic step(input logic lv, input logic [31:0] ld, input logic se);
      sf.load_valid = lv;
      sf.load_data  = ld;
      sf.stream_en  = se;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_beat(input string tag, input int base, input int t);
      check({tag, "_data"}, sf.data_out, exp_out(base, t));
      check({tag, "_valid"}, {28'd0, sf.out_valid}, {28'd0, exp_valid(t)});
      check({tag, "_done"}, {31'd0, sf.tile_done}, {31'd0, (t == 5)});
   endtask

   task automatic chk_idle(input string tag);
      check({tag, "_data"}, sf.data_out, 32'd0);
      check({tag, "_valid"}, {28'd0, sf.out_valid}, 32'd0);
      check({tag, "_done"}, {31'd0, sf.tile_done}, 32'd0);
      check({tag, "_busy"}, {31'd0, sf.busy}, 32'd0);
      check({tag, "_ready"}, {31'd0, sf.load_ready}, 32'd1);
   endtask

   initial begin
      rst           = 1'b1;
      sf.clear      = 1'b0;
      sf.load_valid = 1'b0;
      sf.load_data  = '0;
      sf.stream_en  = 1'b0;
      #12;
      chk_idle("reset");
      @(negedge clk);
      rst = 1'b0;

      // Tile A, then stream A while tile B loads into the other bank.
      for (int k = 0; k < 3; k++) step(1'b1, col(0, k), 1'b0);
      check("a_loaded_busy", {31'd0, sf.busy}, 32'd1);
      check("a_loaded_ready", {31'd0, sf.load_ready}, 32'd1);
      check("a_loaded_valid", {28'd0, sf.out_valid}, 32'd0);
      for (int t = 0; t < 6; t++) begin
         step(t < 3, col(100, t), 1'b1);
         chk_beat("a", 0, t);
         if (t == 2) begin
            check("a_t2_const", sf.data_out, 32'h00201102);
            check("a_t2_vconst", {28'd0, sf.out_valid}, 32'h7);
         end
         if (t >= 2 && t < 5) check("both_full_ready", {31'd0, sf.load_ready}, 32'd0);
      end
      check("a_freed_ready", {31'd0, sf.load_ready}, 32'd1);

      // Tile B follows with no gap; stall three cycles at t=2.
      for (int t = 0; t < 3; t++) begin
         step(1'b0, '0, 1'b1);
         chk_beat("b", 100, t);
      end
      for (int s = 0; s < 3; s++) begin
         step(1'b0, '0, 1'b0);
         check("stall_data", sf.data_out, 32'h00847566);
         check("stall_valid", {28'd0, sf.out_valid}, 32'h7);
         check("stall_done", {31'd0, sf.tile_done}, 32'd0);
      end
      for (int t = 3; t < 6; t++) begin
         step(1'b0, '0, 1'b1);
         chk_beat("b", 100, t);
      end
      step(1'b0, '0, 1'b1);
      chk_idle("empty");

      // Backpressure: both banks full, load_valid held high.
      for (int k = 0; k < 3; k++) step(1'b1, col(0, k), 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, col(60, k), 1'b0);
      check("bp_ready", {31'd0, sf.load_ready}, 32'd0);
      check("bp_busy", {31'd0, sf.busy}, 32'd1);
      for (int t = 0; t < 6; t++) begin
         step(1'b1, col(30, 0), 1'b1);
         chk_beat("c", 0, t);
         check("bp_hold_ready", {31'd0, sf.load_ready}, {31'd0, (t == 5)});
      end
      for (int t = 0; t < 6; t++) begin
         step(t < 3, col(30, t), 1'b1);
         chk_beat("d", 60, t);
      end
      for (int t = 0; t < 6; t++) begin
         step(1'b0, '0, 1'b1);
         chk_beat("e", 30, t);
      end

      // Clear mid-stream with the other bank half loaded.
      for (int k = 0; k < 3; k++) step(1'b1, col(0, k), 1'b0);
      for (int t = 0; t < 3; t++) begin
         step(t < 2, col(90, t), 1'b1);
         chk_beat("f", 0, t);
      end
      sf.clear = 1'b1;
      step(1'b1, col(90, 2), 1'b1);
      sf.clear = 1'b0;
      chk_idle("clear");
      for (int k = 0; k < 3; k++) step(1'b1, col(20, k), 1'b0);
      for (int t = 0; t < 6; t++) begin
         step(1'b0, '0, 1'b1);
         chk_beat("h", 20, t);
      end

      // Asynchronous reset between edges while streaming.
      for (int k = 0; k < 3; k++) step(1'b1, col(5, k), 1'b0);
      for (int t = 0; t < 2; t++) begin
         step(1'b0, '0, 1'b1);
         chk_beat("i", 5, t);
      end
      #2 rst = 1'b1;
      #1;
      chk_idle("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, '0, 1'b0);
      chk_idle("post_rst");
      for (int k = 0; k < 3; k++) step(1'b1, col(40, k), 1'b0);
      for (int t = 0; t < 6; t++) begin
         step(1'b0, '0, 1'b1);
         chk_beat("j", 40, t);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
`default_nettype wire
